dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (combinational read, synchronous byte/half/word write, funct3-encoded size).
- Port 0 is the core load/store unit; port 1 is the debug/DMA master.
- Accepts one request at a time and drives the memory for exactly one cycle.
- Checks alignment and range, then returns a registered response with an error flag.

Parameters:
- ADDR_WIDTH, 32, request/memory address width
- DATA_WIDTH, 32, data width
- MEM_BYTES, 256, byte span of data memory (power of 2; 64 words)
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 has priority with anti-starvation
- MAX_WAIT, 8, cycles port 1 may be refused in FIXED_PRIO mode before a forced grant

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- m0_req_valid  in  1  port 0 request valid
- m0_req_ready  out  1  port 0 request accepted this cycle
- m0_req_we  in  1  1 = store, 0 = load
- m0_req_funct3  in  3  RV32 load/store funct3
- m0_req_addr  in  ADDR_WIDTH  byte address
- m0_req_wdata  in  DATA_WIDTH  store data (low bits used for sb/sh)
- m0_rsp_valid  out  1  port 0 response valid
- m0_rsp_ready  in  1  port 0 response consumed
- m0_rsp_rdata  out  DATA_WIDTH  load data, extended per funct3; 0 for stores/errors
- m0_rsp_err  out  1  misaligned, out-of-range or illegal funct3
- m1_*  (same eight signals, port 1)
- mem_wr_en  out  1  memory write enable
- mem_funct3  out  3  memory funct3
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_rd_data  in  DATA_WIDTH  memory combinational read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async): FSM=IDLE, last_grant=1 so port 0 wins first, wait_cnt=0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, mem_funct3, mem_addr, mem_wr_data, busy.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no valid request: stay in IDLE.
- IDLE, any valid request:
  - Select the winner combinationally and assert its req_ready in the same cycle; the loser's ready stays 0.
  - Latch we/funct3/addr/wdata and the port id; go to ACCESS.
- Round-robin (FIXED_PRIO=0): with both valid, grant the port that is not last_grant. last_grant updates on each grant.
- Fixed priority (FIXED_PRIO=1): port 0 wins ties.
  - wait_cnt increments each IDLE cycle in which port 1 is valid and refused; it clears when port 1 is granted.
  - When wait_cnt == MAX_WAIT, port 1 wins the next tie.
- Error check, done on latched fields at ACCESS:
  - illegal funct3: loads must be 000/001/010/100/101; stores must be 000/001/010.
  - half access with addr[0] = 1.
  - word access with addr[1:0] != 0.
  - addr >= MEM_BYTES.
- ACCESS, one cycle:
  - mem_funct3, mem_addr and mem_wr_data are driven from the latch.
  - mem_wr_en = we & ~err, so the memory writes on the edge that leaves ACCESS.
  - rsp_rdata register captures mem_rd_data for loads without error, otherwise 0.
  - rsp_err register captures err. Go to RESP.
- Memory outputs outside ACCESS: mem_wr_en = 0; address/data/funct3 hold their last values.
- RESP:
  - The granted port's rsp_valid = 1, with rdata/err stable; the other port's rsp_valid stays 0.
  - Return to IDLE on the cycle rsp_ready = 1; hold indefinitely otherwise.
- Latency: request accepted at edge N; memory access in cycle N+1; rsp_valid first high in cycle N+2. Back-to-back throughput is one request per 3 cycles when rsp_ready is tied high.
- No new request is accepted outside IDLE; req_ready = 0 in ACCESS and RESP.
- Stores to the memory's byte lanes are performed by the memory itself from funct3 and addr[1:0]; the arbiter only gates wr_en.
- Reset asserted in ACCESS: mem_wr_en drops asynchronously and no write occurs; a pending response is discarded.

Test Plan:
- m0 sw addr 0x10 data 0xDEADBEEF, then m0 lw 0x10 -> write in ACCESS cycle; load rsp_rdata 0xDEADBEEF, err 0, rsp_valid two cycles after acceptance.
- Both ports valid every cycle, FIXED_PRIO=0, rsp_ready=1 -> grants alternate 0,1,0,1 starting with port 0; no response is routed to the wrong port.
- FIXED_PRIO=1, MAX_WAIT=8, m0 continuously valid, m1 valid -> m1 granted after 8 refusals, then wait_cnt=0.
- m1 lh addr 0x13 and sw addr 0x102 -> both rsp_err=1, rsp_rdata=0, mem_wr_en never asserted, memory unchanged.
- m0 sb 0x21 data 0x80, then lb 0x21 / lbu 0x21 -> rdata 0xFFFFFF80 / 0x00000080.
- m0 sw in flight, rst raised during ACCESS -> no write, all outputs 0, busy=0; m0_rsp_ready held low in RESP keeps rsp_valid and rdata stable for 5 cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter and sequencer in front of a single-port data memory.
//   Port 0 is the core load/store unit and port 1 is the debug/DMA master.
//   One request is accepted at a time. Each request walks through
//   IDLE -> ACCESS -> RESP. The memory is driven for the ACCESS cycle only.
//   The response is registered and carries an error flag. The flag covers
//   an illegal funct3, a misaligned half/word access, or an address that
//   falls outside the memory.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mN_req_valid/ready       request handshake (N = 0, 1)
//   mN_req_we/funct3/addr/wdata
//                            request fields: store flag, RV32 size code,
//                            byte address and store data
//   mN_rsp_valid/ready       response handshake
//   mN_rsp_rdata/err         load data and error flag; both are 0 when the
//                            response is not valid
//   mem_wr_en/funct3/addr/wr_data
//                            memory command; meaningful during ACCESS only
//   mem_rd_data              combinational read data from the memory,
//                            already extended per funct3
//   busy                     sequencer is not in IDLE
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 256,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [2:0]            m0_req_funct3,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [2:0]            m1_req_funct3,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  // One extra bit so that a span equal to 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT  = (ADDR_WIDTH + 1)'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  last_grant;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  grant_valid;
  logic                  grant_port;

  logic                  lat_we;
  logic [2:0]            lat_funct3;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_port;

  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  funct3_ok;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  access_err;

  // Both ports are gathered into small arrays so that the selection and
  // routing logic is written once.
  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [2:0]            req_funct3 [2];
  logic [ADDR_WIDTH-1:0] req_addr   [2];
  logic [DATA_WIDTH-1:0] req_wdata  [2];
  logic [1:0]            req_ready;
  logic [1:0]            rsp_ready;
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata  [2];
  logic [1:0]            rsp_err;

  assign req_valid     = {m1_req_valid, m0_req_valid};
  assign req_we        = {m1_req_we, m0_req_we};
  assign rsp_ready     = {m1_rsp_ready, m0_rsp_ready};
  assign req_funct3[0] = m0_req_funct3;
  assign req_funct3[1] = m1_req_funct3;
  assign req_addr[0]   = m0_req_addr;
  assign req_addr[1]   = m1_req_addr;
  assign req_wdata[0]  = m0_req_wdata;
  assign req_wdata[1]  = m1_req_wdata;

  // Arbitration. A decision is only made in IDLE, so ready can never rise
  // while a request is still in flight.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (state == IDLE) begin
      grant_valid = m0_req_valid | m1_req_valid;
      if (m0_req_valid && m1_req_valid) begin
        if (FIXED_PRIO != 0) begin
          // Port 0 wins ties unless port 1 has been refused too often.
          grant_port = (wait_cnt == WAIT_LIMIT);
        end else begin
          grant_port = ~last_grant;
        end
      end else begin
        grant_port = m1_req_valid;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (rsp_ready[lat_port]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant bookkeeping and request latch. last_grant resets to 1 so that
  // port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_port   <= 1'b0;
    end else if (grant_valid) begin
      last_grant <= grant_port;
      lat_we     <= req_we[grant_port];
      lat_funct3 <= req_funct3[grant_port];
      lat_addr   <= req_addr[grant_port];
      lat_wdata  <= req_wdata[grant_port];
      lat_port   <= grant_port;
    end
  end

  // Anti-starvation counter. It only moves in fixed-priority mode and only
  // during IDLE cycles. At WAIT_LIMIT, port 1 wins the next tie, which
  // clears the counter, so the counter never goes past the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((FIXED_PRIO != 0) && (state == IDLE)) begin
      if (grant_valid && grant_port) begin
        wait_cnt <= '0;
      end else if (m1_req_valid && (wait_cnt != WAIT_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Access checks, evaluated on the latched request.
  always_comb begin
    if (lat_we) begin
      funct3_ok = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) ||
                  (lat_funct3 == 3'b010);
    end else begin
      funct3_ok = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) ||
                  (lat_funct3 == 3'b010) || (lat_funct3 == 3'b100) ||
                  (lat_funct3 == 3'b101);
    end
    misaligned   = ((lat_funct3[1:0] == 2'b01) && lat_addr[0]) ||
                   ((lat_funct3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
    out_of_range = ({1'b0, lat_addr} >= MEM_LIMIT);
    access_err   = ~funct3_ok | misaligned | out_of_range;
  end

  // Response capture at the end of ACCESS. Stores and faulting accesses
  // return zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_rdata_q <= (!lat_we && !access_err) ? mem_rd_data : '0;
      rsp_err_q   <= access_err;
    end
  end

  // Response routing. Only the granted port sees a response. Its data and
  // error are masked to zero whenever its response is not valid.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi] = grant_valid && (grant_port == 1'(gi));
    assign rsp_valid[gi] = (state == RESP) && (lat_port == 1'(gi));
    assign rsp_rdata[gi] = rsp_valid[gi] ? rsp_rdata_q : '0;
    assign rsp_err[gi]   = rsp_valid[gi] & rsp_err_q;
  end

  assign m0_req_ready = req_ready[0];
  assign m1_req_ready = req_ready[1];
  assign m0_rsp_valid = rsp_valid[0];
  assign m1_rsp_valid = rsp_valid[1];
  assign m0_rsp_rdata = rsp_rdata[0];
  assign m1_rsp_rdata = rsp_rdata[1];
  assign m0_rsp_err   = rsp_err[0];
  assign m1_rsp_err   = rsp_err[1];

  // The memory command comes straight from the latch. The latch only loads
  // on the edge that enters ACCESS, so the command holds its last value at
  // other times. The write enable is decoded from the state register, so an
  // asynchronous reset during ACCESS removes it immediately.
  assign mem_wr_en   = (state == ACCESS) && lat_we && !access_err;
  assign mem_funct3  = lat_funct3;
  assign mem_addr    = lat_addr;
  assign mem_wr_data = lat_wdata;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. A round-robin instance is wired to a
//   small byte-lane memory model. The model reads combinationally, returns
//   data extended per funct3, and writes on the clock edge. A second
//   instance runs in fixed-priority mode with a dummy memory and is used
//   only to observe grant order.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;

  logic        m0_req_valid, m0_req_ready, m0_req_we;
  logic [2:0]  m0_req_funct3;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic [31:0] m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we;
  logic [2:0]  m1_req_funct3;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [31:0] m1_rsp_rdata;
  logic        mem_wr_en, busy;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  // fixed-priority instance
  logic        f_m0_req_valid, f_m0_req_ready, f_m1_req_valid, f_m1_req_ready;
  logic        f_m0_rsp_valid, f_m1_rsp_valid, f_m0_rsp_err, f_m1_rsp_err;
  logic        f_rsp_ready, f_mem_wr_en, f_busy;
  logic [2:0]  f_mem_funct3;
  logic [31:0] f_m0_rsp_rdata, f_m1_rsp_rdata, f_mem_addr, f_mem_wr_data;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_we(m0_req_we), .m0_req_funct3(m0_req_funct3),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_we(m1_req_we), .m1_req_funct3(m1_req_funct3),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  dmem_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(8)) u_fp (
    .clk(clk), .rst(rst),
    .m0_req_valid(f_m0_req_valid), .m0_req_ready(f_m0_req_ready),
    .m0_req_we(1'b0), .m0_req_funct3(3'b010),
    .m0_req_addr(32'h0), .m0_req_wdata(32'h0),
    .m0_rsp_valid(f_m0_rsp_valid), .m0_rsp_ready(f_rsp_ready),
    .m0_rsp_rdata(f_m0_rsp_rdata), .m0_rsp_err(f_m0_rsp_err),
    .m1_req_valid(f_m1_req_valid), .m1_req_ready(f_m1_req_ready),
    .m1_req_we(1'b0), .m1_req_funct3(3'b010),
    .m1_req_addr(32'h4), .m1_req_wdata(32'h0),
    .m1_rsp_valid(f_m1_rsp_valid), .m1_rsp_ready(f_rsp_ready),
    .m1_rsp_rdata(f_m1_rsp_rdata), .m1_rsp_err(f_m1_rsp_err),
    .mem_wr_en(f_mem_wr_en), .mem_funct3(f_mem_funct3), .mem_addr(f_mem_addr),
    .mem_wr_data(f_mem_wr_data), .mem_rd_data(32'h0), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 bytes, little-endian byte lanes.
  logic [7:0] mem_b [256];
  logic       mem_clr;
  int         wr_count;
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    mem_rd_data = 32'h0;
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{mem_b[a0][7]}}, mem_b[a0]};
      3'b001:  mem_rd_data = {{16{mem_b[a1][7]}}, mem_b[a1], mem_b[a0]};
      3'b010:  mem_rd_data = {mem_b[a3], mem_b[a2], mem_b[a1], mem_b[a0]};
      3'b100:  mem_rd_data = {24'h0, mem_b[a0]};
      3'b101:  mem_rd_data = {16'h0, mem_b[a1], mem_b[a0]};
      default: mem_rd_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
      wr_count <= 0;
    end else if (mem_wr_en) begin
      wr_count  <= wr_count + 1;
      mem_b[a0] <= mem_wr_data[7:0];
      if (mem_funct3[1:0] != 2'b00) mem_b[a1] <= mem_wr_data[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem_b[a2] <= mem_wr_data[23:16];
        mem_b[a3] <= mem_wr_data[31:24];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    else
      n_pass++;
  endtask

  // One complete transaction on one port of u_rr. It checks acceptance,
  // the ACCESS cycle (write enable, address, no early response) and the
  // response two cycles after acceptance. It then optionally holds
  // rsp_ready low for hold cycles.
  task automatic do_req(input string tag, input bit port, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold);
    int   cyc;
    logic rdy;
    @(posedge clk); #1;
    if (port) begin
      m1_req_valid = 1'b1; m1_req_we = we; m1_req_funct3 = f3;
      m1_req_addr = addr; m1_req_wdata = wdata; m1_rsp_ready = (hold == 0);
    end else begin
      m0_req_valid = 1'b1; m0_req_we = we; m0_req_funct3 = f3;
      m0_req_addr = addr; m0_req_wdata = wdata; m0_rsp_ready = (hold == 0);
    end
    cyc = 0;
    @(negedge clk);
    rdy = port ? m1_req_ready : m0_req_ready;
    while (!rdy && cyc < 20) begin
      @(negedge clk);
      cyc++;
      rdy = port ? m1_req_ready : m0_req_ready;
    end
    check_val({tag, "_ready"}, 32'(rdy), 32'h1);
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    @(negedge clk);
    check_val({tag, "_acc_wr_en"}, 32'(mem_wr_en), 32'(we & ~exp_err));
    check_val({tag, "_acc_addr"}, mem_addr, addr);
    check_val({tag, "_acc_no_rsp"}, 32'(m0_rsp_valid | m1_rsp_valid), 32'h0);
    @(negedge clk);
    check_val({tag, "_rsp_valid"}, 32'(port ? m1_rsp_valid : m0_rsp_valid), 32'h1);
    check_val({tag, "_other_idle"}, 32'(port ? m0_rsp_valid : m1_rsp_valid), 32'h0);
    check_val({tag, "_rdata"}, port ? m1_rsp_rdata : m0_rsp_rdata, exp_rdata);
    check_val({tag, "_err"}, 32'(port ? m1_rsp_err : m0_rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val({tag, "_hold_valid"}, 32'(port ? m1_rsp_valid : m0_rsp_valid), 32'h1);
      check_val({tag, "_hold_rdata"}, port ? m1_rsp_rdata : m0_rsp_rdata, exp_rdata);
    end
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    @(negedge clk);
    check_val({tag, "_done"}, 32'(busy | m0_rsp_valid | m1_rsp_valid), 32'h0);
    $display("txn %s port=%0d we=%0d f3=%0d addr=%08h wdata=%08h exp_rdata=%08h exp_err=%0d",
             tag, port, we, f3, addr, wdata, exp_rdata, exp_err);
  endtask

  // Round-robin observation state
  int rr_g [4];
  int rr_ng, rr_n0, rr_n1;

  task automatic rr_observe();
    if (m0_req_ready && rr_ng < 4) begin rr_g[rr_ng] = 0; rr_ng++; end
    if (m1_req_ready && rr_ng < 4) begin rr_g[rr_ng] = 1; rr_ng++; end
    check_val("rr_single_rsp", 32'(m0_rsp_valid & m1_rsp_valid), 32'h0);
    if (m0_rsp_valid) begin
      check_val("rr_m0_rdata", m0_rsp_rdata, 32'hDEADBEEF);
      rr_n0++;
    end
    if (m1_rsp_valid) begin
      check_val("rr_m1_rdata", m1_rsp_rdata, 32'h55AA33CC);
      rr_n1++;
    end
  endtask

  int wc;
  int fp_g [10];
  int fp_ng;

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_funct3 = 3'b0;
    m0_req_addr = 32'h0; m0_req_wdata = 32'h0; m0_rsp_ready = 1'b1;
    m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_funct3 = 3'b0;
    m1_req_addr = 32'h0; m1_req_wdata = 32'h0; m1_rsp_ready = 1'b1;
    f_m0_req_valid = 1'b0; f_m1_req_valid = 1'b0; f_rsp_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_wr_en", 32'(mem_wr_en), 32'h0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wr_data, 32'h0);
    check_val("rst_mem_f3", 32'(mem_funct3), 32'h0);
    check_val("rst_rsp", 32'({m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err}), 32'h0);
    check_val("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'h0);
    check_val("rst_ready", 32'({m0_req_ready, m1_req_ready}), 32'h0);
    rst = 1'b0; mem_clr = 1'b0;

    // store and load back, plus a port 1 store used later
    do_req("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req("lw10", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req("sw14_m1", 1'b1, 1'b1, 3'b010, 32'h14, 32'h55AA33CC, 32'h0, 1'b0, 0);
    do_req("lw14_m1", 1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 32'h55AA33CC, 1'b0, 0);

    // error cases: misaligned half, misaligned/out-of-range word, pure range
    wc = wr_count;
    do_req("lh13_err", 1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 0);
    do_req("sw102_err", 1'b1, 1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 1'b1, 0);
    do_req("sw100_err", 1'b1, 1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 1'b1, 0);
    do_req("sd_badf3", 1'b0, 1'b1, 3'b011, 32'h8, 32'h11223344, 32'h0, 1'b1, 0);
    check_val("err_no_writes", 32'(wr_count), 32'(wc));
    do_req("lw0_clean", 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 0);

    // byte store, signed and unsigned byte loads
    do_req("sb21", 1'b0, 1'b1, 3'b000, 32'h21, 32'h12345680, 32'h0, 1'b0, 0);
    do_req("lb21", 1'b0, 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    do_req("lbu21", 1'b0, 1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0, 0);
    do_req("lw20", 1'b0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h00008000, 1'b0, 0);

    // response held for 5 cycles with rsp_ready low
    do_req("lw10_hold", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    // reset while a store sits in ACCESS
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_funct3 = 3'b010;
    m0_req_addr = 32'h30; m0_req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check_val("abort_ready", 32'(m0_req_ready), 32'h1);
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    check_val("abort_pre_wr_en", 32'(mem_wr_en), 32'h1);
    wc = wr_count;
    #2 rst = 1'b1;
    #1;
    check_val("abort_wr_en", 32'(mem_wr_en), 32'h0);
    check_val("abort_busy", 32'(busy), 32'h0);
    check_val("abort_mem_addr", mem_addr, 32'h0);
    check_val("abort_mem_wdata", mem_wr_data, 32'h0);
    check_val("abort_rsp", 32'({m0_rsp_valid, m1_rsp_valid, m0_req_ready}), 32'h0);
    @(posedge clk); #1;
    check_val("abort_no_write", 32'(wr_count), 32'(wc));
    @(negedge clk);
    rst = 1'b0;

    // round-robin with both ports always valid, starting fresh from reset
    rr_ng = 0; rr_n0 = 0; rr_n1 = 0;
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_funct3 = 3'b010; m0_req_addr = 32'h10;
    m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_funct3 = 3'b010; m1_req_addr = 32'h14;
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    for (int c = 0; c < 40 && rr_ng < 4; c++) begin
      @(negedge clk);
      rr_observe();
    end
    @(posedge clk); #1;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rr_observe();
    end
    check_val("rr_grants", 32'(rr_ng), 32'd4);
    for (int i = 0; i < 4; i++) check_val("rr_order", 32'(rr_g[i]), 32'(i % 2));
    check_val("rr_m0_rsps", 32'(rr_n0), 32'd2);
    check_val("rr_m1_rsps", 32'(rr_n1), 32'd2);
    $display("txn rr_alternate grants=%0d m0_rsps=%0d m1_rsps=%0d", rr_ng, rr_n0, rr_n1);

    // the aborted store must not have reached memory
    do_req("lw30", 1'b0, 1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0, 0);

    // fixed priority: m1 forced through after 8 refusals
    fp_ng = 0;
    @(posedge clk); #1;
    f_m0_req_valid = 1'b1; f_m1_req_valid = 1'b1;
    for (int c = 0; c < 100 && fp_ng < 10; c++) begin
      @(negedge clk);
      if (f_m0_req_ready) begin fp_g[fp_ng] = 0; fp_ng++; end
      else if (f_m1_req_ready) begin fp_g[fp_ng] = 1; fp_ng++; end
    end
    @(posedge clk); #1;
    f_m0_req_valid = 1'b0; f_m1_req_valid = 1'b0;
    check_val("fp_grants", 32'(fp_ng), 32'd10);
    for (int i = 0; i < 10; i++) check_val("fp_order", 32'(fp_g[i]), (i == 8) ? 32'h1 : 32'h0);
    $display("txn fixed_prio grants=%0d ninth=%0d tenth=%0d", fp_ng, fp_g[8], fp_g[9]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
